// File: rtl/bleuart_pkg.sv
// Shared types and constants for the BLE UART receive path.
// BLEUART_RX_PARITY_EN adds the PARITY receiver state (8E1 framing).
package bleuart_pkg;

    localparam int unsigned BLEUART_DATA_W          = 8;
    localparam int unsigned BLEUART_DEFAULT_TIMEOUT = 868;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_HIGH
`ifdef BLEUART_RX_PARITY_EN
        , ST_PARITY
`endif
    } rx_state_t;

endpackage

// File: rtl/bleuart_rx_fifo.sv
// Receive byte FIFO: power-of-two depth, head entry presented directly from
// the storage registers so dout is registered and stable until popped.
module bleuart_rx_fifo
    import bleuart_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [BLEUART_DATA_W-1:0] din,
    input  logic                      pop,
    output logic [BLEUART_DATA_W-1:0] dout,
    output logic                      valid,
    output logic                      full
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [BLEUART_DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]             wr_ptr;
    logic [AW-1:0]             rd_ptr;
    logic [AW:0]               count;
    logic                      do_push;
    logic                      do_pop;

    assign valid   = (count != '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & valid;
    // A pop frees the slot in the same cycle, so push-while-full is legal then.
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bleuart_rx.sv
// BLE UART byte receiver: RX synchroniser, mid-bit sampling FSM and output FIFO.
// Define BLEUART_RX_PARITY_EN for 8E1 framing with a parity_err pulse.
module bleuart_rx
    import bleuart_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx,
    output logic                      rx_sync,
    input  logic                      r_tick,
    output logic [BLEUART_DATA_W-1:0] out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      frame_err,
    output logic                      overrun
`ifdef BLEUART_RX_PARITY_EN
    ,
    output logic                      parity_err
`endif
);

    rx_state_t                 state, state_n;
    logic                      rx_meta;
    logic [2:0]                bit_cnt, bit_cnt_n;
    logic [BLEUART_DATA_W-1:0] shreg, shreg_n;
    logic                      push;
    logic                      frame_err_n;
    logic                      fifo_full;
    logic                      pop;
`ifdef BLEUART_RX_PARITY_EN
    logic                      par_bad, par_bad_n;
    logic                      parity_err_n;
`endif

    assign pop = out_valid & out_ready;

    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        shreg_n     = shreg;
        push        = 1'b0;
        frame_err_n = 1'b0;
`ifdef BLEUART_RX_PARITY_EN
        par_bad_n    = par_bad;
        parity_err_n = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (!rx_sync) state_n = ST_START;
            end
            ST_START: begin
                if (r_tick) begin
                    if (!rx_sync) begin
                        state_n   = ST_DATA;
                        bit_cnt_n = '0;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (r_tick) begin
                    shreg_n   = {rx_sync, shreg[BLEUART_DATA_W-1:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
`ifdef BLEUART_RX_PARITY_EN
                        state_n = ST_PARITY;
`else
                        state_n = ST_STOP;
`endif
                    end
                end
            end
`ifdef BLEUART_RX_PARITY_EN
            ST_PARITY: begin
                if (r_tick) begin
                    par_bad_n    = ^{shreg, rx_sync};
                    parity_err_n = ^{shreg, rx_sync};
                    state_n      = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (r_tick) begin
                    if (rx_sync) begin
`ifdef BLEUART_RX_PARITY_EN
                        push = ~par_bad;
`else
                        push = 1'b1;
`endif
                        state_n = ST_IDLE;
                    end else begin
                        frame_err_n = 1'b1;
                        state_n     = ST_WAIT_HIGH;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                if (rx_sync) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef BLEUART_RX_PARITY_EN
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            rx_meta   <= rx;
            rx_sync   <= rx_meta;
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            shreg     <= shreg_n;
            frame_err <= frame_err_n;
            overrun   <= push & fifo_full & ~pop;
`ifdef BLEUART_RX_PARITY_EN
            par_bad    <= par_bad_n;
            parity_err <= parity_err_n;
`endif
        end
    end

    bleuart_rx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (shreg),
        .pop   (pop),
        .dout  (out_data),
        .valid (out_valid),
        .full  (fifo_full)
    );

endmodule

// File: tb/tb_bleuart_rx.sv
// Directed self-checking bench for bleuart_rx; r_tick is driven directly at mid-bit.
module tb_bleuart_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       rx_sync;
    logic       r_tick;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       frame_err;
    logic       overrun;
`ifdef BLEUART_RX_PARITY_EN
    logic       parity_err;
    int         perr_cnt = 0;
`endif

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    logic [7:0] got_q [$];
    int         got_cyc [$];

    always #5 clk = ~clk;

    bleuart_rx #(
        .DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .rx_sync    (rx_sync),
        .r_tick     (r_tick),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_err  (frame_err),
        .overrun    (overrun)
`ifdef BLEUART_RX_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    always @(negedge clk) begin
        cyc++;
        if (out_valid && out_ready) begin
            got_q.push_back(out_data);
            got_cyc.push_back(cyc);
        end
        if (frame_err) ferr_cnt++;
        if (overrun) ovr_cnt++;
`ifdef BLEUART_RX_PARITY_EN
        if (parity_err) perr_cnt++;
`endif
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // 8-cycle bit period, strobe placed after the 2-flop sync latency.
    task automatic send_bit(input logic b);
        rx = b;
        idle(4);
        r_tick = 1'b1;
        idle(1);
        r_tick = 1'b0;
        idle(3);
    endtask

    task automatic send_data(input logic [7:0] b);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_data(b);
`ifdef BLEUART_RX_PARITY_EN
        send_bit(^b);
`endif
        send_bit(1'b1);
        idle(4);
    endtask

    int nb, fb, ob;

    initial begin
        rst = 1'b1; rx = 1'b1; r_tick = 1'b0; out_ready = 1'b1;
        idle(3);
        check("rst_valid", out_valid, 1'b0);
        check("rst_data", out_data, 8'h00);
        check("rst_rxsync", rx_sync, 1'b1);
        check("rst_ferr", frame_err, 1'b0);
        check("rst_ovr", overrun, 1'b0);
        rst = 1'b0;
        idle(4);

        // back-to-back bytes
        nb = got_q.size(); fb = ferr_cnt; ob = ovr_cnt;
        send_byte(8'h55);
        send_byte(8'hA3);
        idle(6);
        check("b2b_count", got_q.size() - nb, 2);
        if (got_q.size() >= nb + 2) begin
            check("b2b_byte0", got_q[nb], 8'h55);
            check("b2b_byte1", got_q[nb+1], 8'hA3);
        end
        check("b2b_ferr", ferr_cnt - fb, 0);
        check("b2b_ovr", ovr_cnt - ob, 0);

        // fill FIFO with consumer stalled, fifth byte overruns
        out_ready = 1'b0;
        nb = got_q.size(); ob = ovr_cnt;
        for (int i = 1; i <= 5; i++) send_byte(8'(i));
        idle(4);
        check("ovr_pulses", ovr_cnt - ob, 1);
        check("ovr_held_valid", out_valid, 1'b1);
        check("ovr_held_data", out_data, 8'h01);
        check("ovr_no_pop", got_q.size() - nb, 0);
        out_ready = 1'b1;
        idle(8);
        check("drain_count", got_q.size() - nb, 4);
        if (got_q.size() >= nb + 4) begin
            for (int i = 0; i < 4; i++) check($sformatf("drain_byte%0d", i), got_q[nb+i], 8'(i + 1));
            for (int i = 0; i < 3; i++) check($sformatf("drain_gap%0d", i), got_cyc[nb+i+1] - got_cyc[nb+i], 1);
        end
        check("drain_empty", out_valid, 1'b0);

        // break: 10 low bit times, then stays low a while longer
        nb = got_q.size(); fb = ferr_cnt;
        for (int i = 0; i < 20; i++) send_bit(1'b0);
        check("brk_ferr", ferr_cnt - fb, 1);
        check("brk_nopush", got_q.size() - nb, 0);
        rx = 1'b1;
        idle(16);
        send_byte(8'h7E);
        idle(6);
        check("brk_recover_cnt", got_q.size() - nb, 1);
        if (got_q.size() >= nb + 1) check("brk_recover_byte", got_q[nb], 8'h7E);
        check("brk_ferr_after", ferr_cnt - fb, 1);

        // start-bit glitch rejected at START sampling
        nb = got_q.size(); fb = ferr_cnt;
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(4);
        r_tick = 1'b1;
        idle(1);
        r_tick = 1'b0;
        idle(20);
        check("glitch_nopush", got_q.size() - nb, 0);
        check("glitch_ferr", ferr_cnt - fb, 0);
        send_byte(8'h5A);
        idle(6);
        check("glitch_recover_cnt", got_q.size() - nb, 1);
        if (got_q.size() >= nb + 1) check("glitch_recover_byte", got_q[nb], 8'h5A);

        // reset mid-frame with a byte parked in the FIFO
        out_ready = 1'b0;
        nb = got_q.size();
        send_byte(8'h99);
        check("pre_rst_valid", out_valid, 1'b1);
        check("pre_rst_data", out_data, 8'h99);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        rst = 1'b1;
        idle(1);
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_data", out_data, 8'h00);
        check("mid_rst_rxsync", rx_sync, 1'b1);
        rx = 1'b1;
        idle(1);
        rst = 1'b0;
        out_ready = 1'b1;
        idle(8);
        check("post_rst_empty", got_q.size() - nb, 0);
        send_byte(8'h3C);
        idle(6);
        check("post_rst_cnt", got_q.size() - nb, 1);
        if (got_q.size() >= nb + 1) check("post_rst_byte", got_q[nb], 8'h3C);

`ifdef BLEUART_RX_PARITY_EN
        nb = got_q.size(); fb = perr_cnt;
        send_data(8'h0F);
        send_bit(1'b0);
        send_bit(1'b1);
        idle(8);
        check("par_good_cnt", got_q.size() - nb, 1);
        if (got_q.size() >= nb + 1) check("par_good_byte", got_q[nb], 8'h0F);
        check("par_good_perr", perr_cnt - fb, 0);
        nb = got_q.size();
        send_data(8'h0F);
        send_bit(1'b1);
        send_bit(1'b1);
        idle(8);
        check("par_bad_perr", perr_cnt - fb, 1);
        check("par_bad_nopush", got_q.size() - nb, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
